// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a double-buffered display word.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 1000,
    parameter int DEAD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [3:0]            bcd,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int MAXC = (CLK_DIV > DEAD) ? CLK_DIV : DEAD;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(DIGITS);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic                blank_end, show_end, boundary;

    logic [4*DIGITS-1:0] shadow, active;
    logic [DIGITS-1:0]   shadow_dp, active_dp;

    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic [DIGITS-1:0]   an_sel;
`ifdef SEG7_LZB_EN
    logic                upper_zero;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        idx_nxt   = idx;
        blank_end = (state == BLANK) && (cnt == CW'(DEAD - 1));
        show_end  = (state == SHOW)  && (cnt == CW'(CLK_DIV - 1));
        boundary  = show_end && (idx == IW'(DIGITS - 1));
        if (blank_end) begin
            state_nxt = SHOW;
            cnt_nxt   = '0;
        end else if (show_end) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            idx_nxt   = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end
    end

    // Digit about to be shown: its nibble, decimal point and anode pattern.
    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        an_sel  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib   = active[4*i +: 4];
                cur_dp    = active_dp[i];
                an_sel[i] = 1'b1;
            end
        end
`ifdef SEG7_LZB_EN
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ((IW'(i) >= idx) && (active[4*i +: 4] != 4'd0))
                upper_zero = 1'b0;
        end
        if ((idx != '0) && !cur_dp && upper_zero)
            an_sel = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            bcd        <= '0;
            dp         <= 1'b0;
            an         <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            shadow     <= '0;
            shadow_dp  <= '0;
            active     <= '0;
            active_dp  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            frame_done <= boundary;

            if (blank_end) begin
                an  <= an_sel;
                bcd <= cur_nib;
                dp  <= cur_dp;
            end else if (show_end) begin
                an <= '0;
            end

            // A load landing exactly on the boundary skips the shadow entirely.
            if (boundary && load) begin
                active    <= data_in;
                active_dp <= dp_in;
                pending   <= 1'b0;
            end else if (boundary && pending) begin
                active    <= shadow;
                active_dp <= shadow_dp;
                pending   <= 1'b0;
            end else if (load) begin
                shadow    <= data_in;
                shadow_dp <= dp_in;
                pending   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl (DIGITS=4, CLK_DIV=4, DEAD=1).
// Define SEG7_LZB_EN to also exercise leading-zero blanking.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  bcd;
    logic        dp;
    logic [3:0]  an;
    logic        pending;
    logic        frame_done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    seg7_scan_ctrl #(.DIGITS(4), .CLK_DIV(4), .DEAD(1)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
        .bcd(bcd), .dp(dp), .an(an), .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Expected anode for cycle c after release: 5-cycle slots, lit in the first 4.
    function automatic logic [3:0] exp_an(int c, logic [15:0] w, logic [3:0] d);
        int pos;
        int dig;
        if (c < 1) return 4'b0000;
        pos = (c - 1) % 20;
        dig = pos / 5;
        if (pos % 5 == 4) return 4'b0000;
`ifdef SEG7_LZB_EN
        if (dig > 0 && !d[dig] && ((w >> (4 * dig)) == 16'd0)) return 4'b0000;
`endif
        return 4'(1 << dig);
    endfunction

    function automatic int exp_dig(int c);
        return ((c - 1) % 20) / 5;
    endfunction

    task automatic test_reset();
        logic [3:0] e;
        rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        tests++;
        if (an !== 4'b0000 || bcd !== 4'd0 || dp !== 1'b0 || pending !== 1'b0 || frame_done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_values an=%b bcd=%h dp=%b pend=%b fd=%b expected all zero",
                     an, bcd, dp, pending, frame_done);
        end
        for (int k = 0; k < 40; k++) begin
            tick();
            e = exp_an(cyc, 16'h0000, 4'b0000);
            tests++;
            if (an !== e) begin
                fails++;
                $display("[TB] FAIL reset_scan_an cyc=%0d an=%b expected %b", cyc, an, e);
            end
            tests++;
            if (frame_done !== (cyc % 20 == 0)) begin
                fails++;
                $display("[TB] FAIL reset_frame_done cyc=%0d got=%b expected %b", cyc, frame_done, cyc % 20 == 0);
            end
        end
    endtask

    task automatic test_load_boundary();
        logic [15:0] w = 16'h4321;
        logic [3:0]  d = 4'b0100;
        logic [3:0]  e;
        int          g;
        repeat (7) tick();
        load = 1'b1; data_in = w; dp_in = d;
        tick();
        load = 1'b0; data_in = '0; dp_in = '0;
        while (cyc % 20 != 0) begin
            tests++;
            if (pending !== 1'b1) begin
                fails++;
                $display("[TB] FAIL load_pending cyc=%0d got=%b expected 1", cyc, pending);
            end
            tick();
        end
        tests++;
        if (pending !== 1'b0 || frame_done !== 1'b1) begin
            fails++;
            $display("[TB] FAIL load_boundary pend=%b fd=%b expected pend=0 fd=1", pending, frame_done);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            e = exp_an(cyc, w, d);
            tests++;
            if (an !== e) begin
                fails++;
                $display("[TB] FAIL load_an cyc=%0d an=%b expected %b", cyc, an, e);
            end
            if (e != 4'b0000) begin
                g = exp_dig(cyc);
                tests++;
                if (bcd !== w[4*g +: 4] || dp !== d[g]) begin
                    fails++;
                    $display("[TB] FAIL load_digit cyc=%0d bcd=%h dp=%b expected %h %b", cyc, bcd, dp, w[4*g +: 4], d[g]);
                end
            end
        end
    endtask

    task automatic test_double_load();
        logic [3:0] e;
        repeat (2) tick();
        load = 1'b1; data_in = 16'h1111; dp_in = 4'b0000;
        tick();
        data_in = 16'h2222;
        tick();
        load = 1'b0; data_in = '0;
        tests++;
        if (pending !== 1'b1) begin
            fails++;
            $display("[TB] FAIL dbl_pending got=%b expected 1", pending);
        end
        while (cyc % 20 != 0) tick();
        tests++;
        if (pending !== 1'b0 || frame_done !== 1'b1) begin
            fails++;
            $display("[TB] FAIL dbl_boundary pend=%b fd=%b expected pend=0 fd=1", pending, frame_done);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            e = exp_an(cyc, 16'h2222, 4'b0000);
            tests++;
            if (an !== e) begin
                fails++;
                $display("[TB] FAIL dbl_an cyc=%0d an=%b expected %b", cyc, an, e);
            end
            if (e != 4'b0000) begin
                tests++;
                if (bcd !== 4'h2 || dp !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL dbl_digit cyc=%0d bcd=%h dp=%b expected 2 0", cyc, bcd, dp);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] w = 16'h9876;
        logic [3:0]  e;
        int          g;
        while (cyc % 20 != 19) tick();
        load = 1'b1; data_in = w; dp_in = 4'b0000;
        tick();
        load = 1'b0; data_in = '0;
        tests++;
        if (frame_done !== 1'b1 || pending !== 1'b0) begin
            fails++;
            $display("[TB] FAIL sim_boundary fd=%b pend=%b expected fd=1 pend=0", frame_done, pending);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            e = exp_an(cyc, w, 4'b0000);
            tests++;
            if (an !== e || pending !== 1'b0) begin
                fails++;
                $display("[TB] FAIL sim_an cyc=%0d an=%b pend=%b expected %b 0", cyc, an, pending, e);
            end
            if (e != 4'b0000) begin
                g = exp_dig(cyc);
                tests++;
                if (bcd !== w[4*g +: 4]) begin
                    fails++;
                    $display("[TB] FAIL sim_digit cyc=%0d bcd=%h expected %h", cyc, bcd, w[4*g +: 4]);
                end
            end
        end
    endtask

    task automatic test_non_bcd();
        logic [15:0] w = 16'hFA0B;
        logic [3:0]  d = 4'b1010;
        logic [3:0]  e;
        int          g;
        tick();
        load = 1'b1; data_in = w; dp_in = d;
        tick();
        load = 1'b0; data_in = '0; dp_in = '0;
        while (cyc % 20 != 0) tick();
        for (int k = 0; k < 20; k++) begin
            tick();
            e = exp_an(cyc, w, d);
            tests++;
            if (an !== e) begin
                fails++;
                $display("[TB] FAIL nonbcd_an cyc=%0d an=%b expected %b", cyc, an, e);
            end
            if (e != 4'b0000) begin
                g = exp_dig(cyc);
                tests++;
                if (bcd !== w[4*g +: 4] || dp !== d[g]) begin
                    fails++;
                    $display("[TB] FAIL nonbcd_digit cyc=%0d bcd=%h dp=%b expected %h %b", cyc, bcd, dp, w[4*g +: 4], d[g]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e;
        repeat (2) tick();
        load = 1'b1; data_in = 16'h5555; dp_in = 4'b1111;
        tick();
        load = 1'b0; data_in = '0; dp_in = '0;
        while ((cyc - 1) % 20 != 11) tick();
        tests++;
        if (an !== 4'b0100 || pending !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_pre an=%b pend=%b expected 0100 1", an, pending);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
        tests++;
        if (an !== 4'b0000 || pending !== 1'b0 || bcd !== 4'd0 || dp !== 1'b0 || frame_done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_reset an=%b pend=%b bcd=%h dp=%b fd=%b expected all zero",
                     an, pending, bcd, dp, frame_done);
        end
        for (int k = 0; k < 40; k++) begin
            tick();
            e = exp_an(cyc, 16'h0000, 4'b0000);
            tests++;
            if (an !== e || pending !== 1'b0 || frame_done !== (cyc % 20 == 0)) begin
                fails++;
                $display("[TB] FAIL mid_after cyc=%0d an=%b pend=%b fd=%b expected %b 0 %b",
                         cyc, an, pending, frame_done, e, cyc % 20 == 0);
            end
            if (e != 4'b0000) begin
                tests++;
                if (bcd !== 4'd0 || dp !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL mid_digit cyc=%0d bcd=%h dp=%b expected 0 0", cyc, bcd, dp);
                end
            end
        end
    endtask

`ifdef SEG7_LZB_EN
    task automatic test_lzb();
        logic [3:0] e;
        tick();
        load = 1'b1; data_in = 16'h0050; dp_in = 4'b0000;
        tick();
        load = 1'b0; data_in = '0;
        while (cyc % 20 != 0) tick();
        for (int k = 0; k < 20; k++) begin
            tick();
            case ((cyc - 1) % 20)
                0, 1, 2, 3: e = 4'b0001;
                5, 6, 7, 8: e = 4'b0010;
                default:    e = 4'b0000;
            endcase
            tests++;
            if (an !== e) begin
                fails++;
                $display("[TB] FAIL lzb_an cyc=%0d an=%b expected %b", cyc, an, e);
            end
            if (e != 4'b0000) begin
                tests++;
                if (bcd !== ((e == 4'b0001) ? 4'd0 : 4'd5)) begin
                    fails++;
                    $display("[TB] FAIL lzb_digit cyc=%0d bcd=%h", cyc, bcd);
                end
            end
            tests++;
            if (frame_done !== (cyc % 20 == 0)) begin
                fails++;
                $display("[TB] FAIL lzb_frame cyc=%0d fd=%b expected %b", cyc, frame_done, cyc % 20 == 0);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_boundary();
        test_double_load();
        test_simultaneous();
        test_non_bcd();
        test_reset_mid();
`ifdef SEG7_LZB_EN
        test_lzb();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexing scan controller: one BCD-to-7-segment decoder drives DIGITS common-anode/cathode digits.
- Each cycle the block chooses the digit that owns the decoder, presents its BCD nibble and decimal point, and enables that digit's anode.
- The host writes a full display word with a `load` pulse. The word is double-buffered so it only takes effect at a frame boundary, which prevents tearing.
- Sits between the host/data logic and the existing BCD decoder. Controller `bcd[3:0]` maps to decoder inputs A=bcd[3], B=bcd[2], C=bcd[1], D=bcd[0].

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- CLK_DIV, 1000, clock cycles each digit is lit per visit (>=1).
- DEAD, 2, blanking cycles between digits for anti-ghosting (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  single-cycle request: capture data_in/dp_in into the shadow register.
- data_in  in  4*DIGITS  BCD nibbles; digit i = data_in[4i+3:4i], digit 0 is least significant.
- dp_in  in  DIGITS  decimal point per digit.
- bcd  out  4  nibble to the shared decoder.
- dp  out  1  decimal point to the decoder/segment driver.
- an  out  DIGITS  one-hot digit enable, active-high; all-zero while blanking.
- pending  out  1  shadow holds data not yet displayed.
- frame_done  out  1  one-cycle pulse when the last digit's SHOW phase ends.

Behaviour:
- **Interface:** one clock; reset is synchronous and active-high (clk, rst).
- **Registered outputs:** all outputs are registered.
- **Reset values:** bcd=0, dp=0, an=0, pending=0, frame_done=0. Shadow and active registers clear to 0. Digit index=0, counter=0, state=BLANK.
- **Two-state FSM:**
  - BLANK: an=0. Lasts DEAD cycles, then go to SHOW.
  - SHOW: an=one-hot(idx); bcd/dp come from active[idx]. Lasts exactly CLK_DIV cycles. Then idx advances (DIGITS-1 wraps to 0) and the FSM returns to BLANK.
- **Digit period and latency:** digit period = DEAD+CLK_DIV cycles; frame = DIGITS*(DEAD+CLK_DIV) cycles. After rst deasserts, digit 0 first lights at cycle DEAD+1.
- **Output timing:** bcd/dp update in the same cycle an becomes nonzero; they hold during BLANK.
- **load:** captures shadow<=data_in and dp_in, and sets pending=1 on the next edge. A second load before the boundary overwrites the shadow (last write wins).
- **Frame boundary** (SHOW->BLANK transition with idx=DIGITS-1):
  - frame_done=1 for one cycle.
  - If pending: active<=shadow, pending<=0.
- **load coinciding with the boundary:** data_in bypasses the shadow straight into active; pending stays 0.
- **Non-BCD nibbles (10..15):** passed to bcd unchanged; the decoder defines the glyph.
- **Reset mid-frame:** immediate return to reset values; any pending load is discarded.
- **Counter width:** the counter is wide enough for max(CLK_DIV,DEAD)-1 and wraps to 0 on each state change.

Optional Feature:
- **Macro:** SEG7_LZB_EN, leading-zero blanking.
- **Defined:** in SHOW for digit idx>0, an stays 0 if active[idx]==0 and every more-significant nibble is also 0. Timing is unchanged (the slot still consumes CLK_DIV cycles). Digit 0 is never blanked, and a dp bit set on a digit prevents blanking of that digit.
- **Undefined:** every digit is lit regardless of value; no extra logic is synthesized.

Test Plan (DIGITS=4, CLK_DIV=4, DEAD=1 unless noted):
- **Reset/scan:** hold rst 3 cycles, then release with active=0.
  - Required: an=0000 for 1 cycle, then 0001 for 4, 0000 for 1, then 0010 for 4, and so on.
  - Required: frame_done pulses at cycle 20 after release, then every 20 cycles.
- **Load at boundary:** load data_in=16'h4321, dp_in=4'b0100 mid-frame.
  - Required: pending=1 until the boundary; the next frame shows bcd 1,2,3,4 on an 0001,0010,0100,1000.
  - Required: dp=1 only while an=0100.
- **Double load:** load 16'h1111, then load 16'h2222 before the boundary.
  - Required: the next frame shows only 2s; pending clears at frame_done.
- **Simultaneous load and boundary:** load 16'h9876 in the cycle frame_done is generated.
  - Required: the next frame shows 6,7,8,9; pending stays 0.
- **Reset mid-operation:** assert rst during SHOW of digit 2 with pending=1.
  - Required: next cycle an=0, pending=0; the following frame displays 0000.
- **SEG7_LZB_EN defined:** load 16'h0050.
  - Required: digit0 shows 0 (an=0001) and digit1 shows 5 (an=0010).
  - Required: digit2/digit3 slots keep an=0000 for 4 cycles each.
  - Required: the frame is still 20 cycles.
